flag_setting_unit: RTL and testbench

Producer side of the condition-flag interface: computes NZCV from the ALU result of flag-setting instructions and delivers `ALUFlags` to the ConditionalUnit. Flag updates pass through a one-entry pending stage and then commit to the architectural flag register. A forwarded view of the pending flags is provided so condition evaluation always sees the newest flags. A shadow register saves and restores flags on exception entry and exit.

---
 rtl/flag_setting_unit.sv | 133 +++++++++++++
 tb/tb_flag_setting_unit.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/flag_setting_unit.sv
// flag_setting_unit
//
// Producer side of the condition-flag interface. Computes NZCV from the ALU
// result of flag-setting instructions and passes each update through a
// one-entry pending stage before committing it to the architectural flag
// register. A forwarded view (flags_fwd) always shows the newest flags, and a
// shadow register saves/restores the committed flags around exceptions.
//
// Ports:
//   clk           in  1      rising-edge clock
//   rst           in  1      synchronous reset, active-high
//   alu_a         in  WIDTH  ALU operand A
//   alu_b         in  WIDTH  ALU operand B (not inverted for sub)
//   alu_result    in  WIDTH  ALU result
//   alu_carry     in  1      adder carry-out (sub: carry of a+~b+1, 1 = no borrow)
//   alu_op        in  2      00 add, 01 sub, 10 logic, 11 move
//   flag_we       in  1      instruction sets flags
//   cond_pass     in  1      instruction passed its condition check
//   stall         in  1      freeze pending and commit stages
//   flush         in  1      kill pending and current flag updates
//   flags_save    in  1      copy ALUFlags into the shadow register
//   flags_restore in  1      load the shadow register into ALUFlags
//   ALUFlags      out 4      committed flags {N,Z,C,V}
//   flags_fwd     out 4      pending flags when pend_valid, else ALUFlags
//   pend_valid    out 1      an update is waiting to commit

module flag_setting_unit #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] alu_a,
    input  logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_carry,
    input  logic [1:0]       alu_op,
    input  logic             flag_we,
    input  logic             cond_pass,
    input  logic             stall,
    input  logic             flush,
    input  logic             flags_save,
    input  logic             flags_restore,
    output logic [3:0]       ALUFlags,
    output logic [3:0]       flags_fwd,
    output logic             pend_valid
);

    localparam int MSB = WIDTH - 1;

    typedef enum logic [1:0] {
        OP_ADD   = 2'b00,
        OP_SUB   = 2'b01,
        OP_LOGIC = 2'b10,
        OP_MOVE  = 2'b11
    } alu_op_t;

    logic [3:0] pend_flags;
    logic [3:0] shadow;
    logic [3:0] comp_flags;
    logic       capture;
    logic       flag_n;
    logic       flag_z;
    logic       flag_c;
    logic       flag_v;

    // Forwarded view: driven from registers only, so there is no
    // input-to-output path through the unit.
    assign flags_fwd = pend_valid ? pend_flags : ALUFlags;

    // Logic and move keep C and V from the forwarded flags so that a chain of
    // back-to-back flag-setting instructions sees the still-pending values.
    always_comb begin
        flag_n = alu_result[MSB];
        flag_z = (alu_result == '0);
        flag_c = flags_fwd[1];
        flag_v = flags_fwd[0];
        unique case (alu_op_t'(alu_op))
            OP_ADD: begin
                flag_c = alu_carry;
                flag_v = (alu_a[MSB] == alu_b[MSB]) && (alu_result[MSB] != alu_a[MSB]);
            end
            OP_SUB: begin
                flag_c = alu_carry;
                flag_v = (alu_a[MSB] != alu_b[MSB]) && (alu_result[MSB] != alu_a[MSB]);
            end
            default: begin
                flag_c = flags_fwd[1];
                flag_v = flags_fwd[0];
            end
        endcase
        comp_flags = {flag_n, flag_z, flag_c, flag_v};
    end

    // A new update is only accepted when nothing higher in priority
    // (restore, flush, stall) is claiming this edge.
    assign capture = flag_we & cond_pass & ~stall & ~flush & ~flags_restore;

    // Pending/commit stages. Restore beats flush beats stall; in the normal
    // case the pending entry commits while the next capture refills it, so
    // one update per cycle flows through without bubbles.
    always_ff @(posedge clk) begin
        if (rst) begin
            ALUFlags   <= 4'b0000;
            pend_flags <= 4'b0000;
            pend_valid <= 1'b0;
        end else if (flags_restore) begin
            ALUFlags   <= shadow;
            pend_valid <= 1'b0;
        end else if (flush) begin
            pend_valid <= 1'b0;
        end else if (!stall) begin
            if (pend_valid) begin
                ALUFlags <= pend_flags;
            end
            pend_valid <= capture;
            if (capture) begin
                pend_flags <= comp_flags;
            end
        end
    end

    // Shadow register. Save captures the committed flags as they were before
    // this edge and ignores stall/flush; a save alongside a restore is
    // dropped so the restored value is not clobbered.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow <= 4'b0000;
        end else if (flags_save && !flags_restore) begin
            shadow <= ALUFlags;
        end
    end

endmodule

// File: tb/tb_flag_setting_unit.sv
// Directed testbench for flag_setting_unit. Inputs change on the falling edge
// and outputs are sampled on the falling edge, away from the active edge.

module tb_flag_setting_unit;

    localparam int WIDTH = 16;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] alu_result;
    logic             alu_carry;
    logic [1:0]       alu_op;
    logic             flag_we;
    logic             cond_pass;
    logic             stall;
    logic             flush;
    logic             flags_save;
    logic             flags_restore;
    logic [3:0]       ALUFlags;
    logic [3:0]       flags_fwd;
    logic             pend_valid;

    int errors = 0;
    int checks = 0;

    flag_setting_unit #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_result   (alu_result),
        .alu_carry    (alu_carry),
        .alu_op       (alu_op),
        .flag_we      (flag_we),
        .cond_pass    (cond_pass),
        .stall        (stall),
        .flush        (flush),
        .flags_save   (flags_save),
        .flags_restore(flags_restore),
        .ALUFlags     (ALUFlags),
        .flags_fwd    (flags_fwd),
        .pend_valid   (pend_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one ALU operation; we/cp select whether it tries to set flags.
    task automatic applyStimulus(input logic [1:0] op, input logic [15:0] a,
                                 input logic [15:0] b, input logic [15:0] r,
                                 input logic carry, input logic we, input logic cp);
        alu_op     = op;
        alu_a      = a;
        alu_b      = b;
        alu_result = r;
        alu_carry  = carry;
        flag_we    = we;
        cond_pass  = cp;
    endtask

    // Let one rising edge pass and return on the following falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%b expected=%b", tag, got, exp);
        end
    endtask

    task automatic idle();
        applyStimulus(2'b00, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        flags_save = 1'b0; flags_restore = 1'b0;
        idle();
        @(negedge clk);
        step();
        step();
        rst = 1'b0;
        $display("[TB] reset released");
        checkOutput("reset_flags", ALUFlags, 4'b0000);
        checkOutput("reset_fwd", flags_fwd, 4'b0000);
        checkOutput("reset_pend", {3'b000, pend_valid}, 4'b0000);

        // add 0x7FFF + 1 -> 0x8000: N and V set
        applyStimulus(2'b00, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b1);
        step();
        idle();
        checkOutput("addovf_fwd", flags_fwd, 4'b1001);
        checkOutput("addovf_pend", {3'b000, pend_valid}, 4'b0001);
        checkOutput("addovf_flags_hold", ALUFlags, 4'b0000);
        step();
        checkOutput("addovf_flags", ALUFlags, 4'b1001);
        checkOutput("addovf_pend_clr", {3'b000, pend_valid}, 4'b0000);

        // sub 5-5 then logic back-to-back (C forwarded from pending)
        applyStimulus(2'b01, 16'h0005, 16'h0005, 16'h0000, 1'b1, 1'b1, 1'b1);
        step();
        checkOutput("subeq_fwd", flags_fwd, 4'b0110);
        applyStimulus(2'b10, 16'h0000, 16'h0000, 16'h8000, 1'b0, 1'b1, 1'b1);
        step();
        idle();
        checkOutput("subeq_flags", ALUFlags, 4'b0110);
        checkOutput("logic_fwd", flags_fwd, 4'b1010);
        step();
        checkOutput("logic_flags", ALUFlags, 4'b1010);

        // suppression: cond_pass=0, then flush
        applyStimulus(2'b01, 16'h0003, 16'h0005, 16'hFFFE, 1'b0, 1'b1, 1'b0);
        step();
        checkOutput("condfail_pend", {3'b000, pend_valid}, 4'b0000);
        checkOutput("condfail_flags", ALUFlags, 4'b1010);
        applyStimulus(2'b00, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        idle();
        checkOutput("flush_pend", {3'b000, pend_valid}, 4'b0000);
        checkOutput("flush_flags", ALUFlags, 4'b1010);
        step();
        checkOutput("flush_flags_after", ALUFlags, 4'b1010);

        // stall for 3 cycles holds the pending sub 3-5
        applyStimulus(2'b01, 16'h0003, 16'h0005, 16'hFFFE, 1'b0, 1'b1, 1'b1);
        step();
        idle();
        checkOutput("stall_cap_fwd", flags_fwd, 4'b1000);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput("stall_pend", {3'b000, pend_valid}, 4'b0001);
            checkOutput("stall_flags", ALUFlags, 4'b1010);
        end
        stall = 1'b0;
        step();
        checkOutput("stall_commit", ALUFlags, 4'b1000);
        checkOutput("stall_pend_clr", {3'b000, pend_valid}, 4'b0000);

        // sub overflow 0x8000-1 -> 0x7FFF, then move keeps C,V
        applyStimulus(2'b01, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1, 1'b1);
        step();
        idle();
        checkOutput("subovf_fwd", flags_fwd, 4'b0011);
        step();
        checkOutput("subovf_flags", ALUFlags, 4'b0011);
        applyStimulus(2'b11, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b1);
        step();
        idle();
        checkOutput("move_fwd", flags_fwd, 4'b0111);
        step();
        checkOutput("move_flags", ALUFlags, 4'b0111);

        // save 0110, capture 1001, restore while pending
        applyStimulus(2'b01, 16'h0005, 16'h0005, 16'h0000, 1'b1, 1'b1, 1'b1);
        step();
        idle();
        step();
        checkOutput("save_setup", ALUFlags, 4'b0110);
        flags_save = 1'b1;
        step();
        flags_save = 1'b0;
        applyStimulus(2'b00, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b1);
        step();
        idle();
        checkOutput("restore_pre_pend", {3'b000, pend_valid}, 4'b0001);
        flags_restore = 1'b1;
        step();
        flags_restore = 1'b0;
        checkOutput("restore_flags", ALUFlags, 4'b0110);
        checkOutput("restore_pend", {3'b000, pend_valid}, 4'b0000);
        checkOutput("restore_fwd", flags_fwd, 4'b0110);
        step();
        checkOutput("restore_hold", ALUFlags, 4'b0110);

        // stall and flush together: flush wins, nothing commits
        applyStimulus(2'b00, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b1);
        step();
        idle();
        stall = 1'b1;
        flush = 1'b1;
        step();
        stall = 1'b0;
        flush = 1'b0;
        checkOutput("stallflush_pend", {3'b000, pend_valid}, 4'b0000);
        checkOutput("stallflush_flags", ALUFlags, 4'b0110);

        // save concurrent with restore is ignored
        applyStimulus(2'b00, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b1);
        step();
        idle();
        step();
        checkOutput("saverest_setup", ALUFlags, 4'b1001);
        flags_save = 1'b1;
        flags_restore = 1'b1;
        step();
        flags_save = 1'b0;
        flags_restore = 1'b0;
        checkOutput("saverest_flags", ALUFlags, 4'b0110);
        applyStimulus(2'b00, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b1);
        step();
        idle();
        step();
        flags_restore = 1'b1;
        step();
        flags_restore = 1'b0;
        checkOutput("saverest_shadow", ALUFlags, 4'b0110);

        // reset mid-operation drops the pending update and clears shadow
        applyStimulus(2'b00, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b1);
        step();
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checkOutput("midrst_flags", ALUFlags, 4'b0000);
        checkOutput("midrst_fwd", flags_fwd, 4'b0000);
        checkOutput("midrst_pend", {3'b000, pend_valid}, 4'b0000);
        applyStimulus(2'b01, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1, 1'b1);
        step();
        idle();
        step();
        checkOutput("midrst_setup", ALUFlags, 4'b0011);
        flags_restore = 1'b1;
        step();
        flags_restore = 1'b0;
        checkOutput("midrst_shadow", ALUFlags, 4'b0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
